// File: rtl/ds1302_pkg.sv
// Shared constants, FSM state type and command decode for the DS1302 command controller.
package ds1302_pkg;

  localparam logic [7:0] CMD_WR_UNPROTECT = 8'h80;
  localparam logic [7:0] CMD_WR_HOUR      = 8'h40;
  localparam logic [7:0] CMD_WR_MINUTE    = 8'h20;
  localparam logic [7:0] CMD_WR_SECOND    = 8'h10;
  localparam logic [7:0] CMD_WR_PROTECT   = 8'h08;
  localparam logic [7:0] CMD_RD_HOUR      = 8'h04;
  localparam logic [7:0] CMD_RD_MINUTE    = 8'h02;
  localparam logic [7:0] CMD_RD_SECOND    = 8'h01;

  localparam logic [7:0] ADDR_SECOND = 8'h80;
  localparam logic [7:0] ADDR_MINUTE = 8'h82;
  localparam logic [7:0] ADDR_HOUR   = 8'h84;
  localparam logic [7:0] ADDR_CTRL   = 8'h8E;

  localparam logic [7:0] WP_ON  = 8'h80;
  localparam logic [7:0] WP_OFF = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_RECOVER, ST_DONE, ST_WAIT_CLR
  } state_e;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic       rd;
  } xfer_t;

  // Highest set command bit wins; read addresses are the write address with bit 0 set.
  function automatic xfer_t cmd_decode(input logic [7:0] cmd, input logic [7:0] wdata);
    xfer_t x;
    x.addr = ADDR_SECOND | 8'h01;
    x.data = 8'h00;
    x.rd   = 1'b1;
    if (cmd[7])      begin x.addr = ADDR_CTRL;           x.data = WP_OFF; x.rd = 1'b0; end
    else if (cmd[6]) begin x.addr = ADDR_HOUR;           x.data = wdata;  x.rd = 1'b0; end
    else if (cmd[5]) begin x.addr = ADDR_MINUTE;         x.data = wdata;  x.rd = 1'b0; end
    else if (cmd[4]) begin x.addr = ADDR_SECOND;         x.data = wdata;  x.rd = 1'b0; end
    else if (cmd[3]) begin x.addr = ADDR_CTRL;           x.data = WP_ON;  x.rd = 1'b0; end
    else if (cmd[2]) begin x.addr = ADDR_HOUR | 8'h01;   x.rd = 1'b1; end
    else if (cmd[1]) begin x.addr = ADDR_MINUTE | 8'h01; x.rd = 1'b1; end
    return x;
  endfunction

endpackage

// File: rtl/ds1302_shift.sv
// Half-period timer and 16-slot serial engine: address byte then data byte, LSB first.
module ds1302_shift #(
  parameter int HALF_DIV = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_addr,
  input  logic [7:0] load_data,
  input  logic       load_rd,
  input  logic       start,
  input  logic       rtc_io_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       io_out,
  output logic       io_oe
);
  localparam int CW = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    slot_q, slot_d, slot_nxt;
  logic          hi_q, hi_d;
  logic          busy_q, busy_d;
  logic          sclk_q, sclk_d;
  logic          io_q, io_d;
  logic          oe_q, oe_d;
  logic          rd_q, rd_d;
  logic [15:0]   tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;

  assign slot_nxt = slot_q + 4'd1;

  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    hi_d   = hi_q;
    busy_d = busy_q;
    sclk_d = sclk_q;
    io_d   = io_q;
    oe_d   = oe_q;
    rd_d   = rd_q;
    tx_d   = tx_q;
    rx_d   = rx_q;
    done   = 1'b0;
    if (load) begin
      tx_d   = {load_data, load_addr};
      rd_d   = load_rd;
      oe_d   = 1'b1;
      io_d   = load_addr[0];
      sclk_d = 1'b0;
      busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      slot_d = 4'd0;
      hi_d   = 1'b0;
      sclk_d = 1'b0;
      io_d   = tx_q[0];
    end else if (busy_q) begin
      if (cnt_q != CNT_LAST) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = '0;
        if (!hi_q) begin
          // Last low-phase cycle: the device has had a full half-period to drive IO.
          hi_d   = 1'b1;
          sclk_d = 1'b1;
          if (rd_q && slot_q[3]) rx_d = {rtc_io_in, rx_q[7:1]};
        end else if (slot_q == 4'd15) begin
          busy_d = 1'b0;
          done   = 1'b1;
          hi_d   = 1'b0;
          sclk_d = 1'b0;
          io_d   = 1'b0;
          oe_d   = 1'b0;
        end else begin
          slot_d = slot_nxt;
          hi_d   = 1'b0;
          sclk_d = 1'b0;
          io_d   = (rd_q && slot_nxt[3]) ? 1'b0 : tx_q[slot_nxt];
          if (rd_q && slot_nxt == 4'd8) oe_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      slot_q <= 4'd0;
      hi_q   <= 1'b0;
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      io_q   <= 1'b0;
      oe_q   <= 1'b0;
      rd_q   <= 1'b0;
      tx_q   <= 16'h0000;
      rx_q   <= 8'h00;
    end else begin
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
      hi_q   <= hi_d;
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      io_q   <= io_d;
      oe_q   <= oe_d;
      rd_q   <= rd_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
    end
  end

  assign busy    = busy_q;
  assign rx_data = rx_q;
  assign sclk    = sclk_q;
  assign io_out  = io_q;
  assign io_oe   = oe_q;

endmodule

// File: rtl/ds1302_cmd_ctrl.sv
// Turns one-hot rtc_control commands into complete DS1302 3-wire transactions.
module ds1302_cmd_ctrl #(
  parameter int HALF_DIV = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd_sig,
  input  logic [7:0] time_write_data,
  output logic       cmd_done,
  output logic [7:0] time_read_data,
  output logic       rtc_ce,
  output logic       rtc_sclk,
  output logic       rtc_io_out,
  output logic       rtc_io_oe,
  input  logic       rtc_io_in
);
  import ds1302_pkg::*;

  localparam int TW = $clog2(2 * HALF_DIV);
  localparam logic [TW-1:0] TMR_LAST = TW'(2 * HALF_DIV - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          ce_q, ce_d;
  logic          rd_q, rd_d;
  logic          done_q, done_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          sh_load, sh_start, sh_busy, sh_done;
  logic [7:0]    sh_rx;
  xfer_t         xfer;

  assign xfer = cmd_decode(cmd_sig, time_write_data);

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    ce_d     = ce_q;
    rd_d     = rd_q;
    rdata_d  = rdata_q;
    sh_load  = 1'b0;
    sh_start = 1'b0;
    done_d   = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (cmd_sig != 8'h00) begin
          sh_load = 1'b1;
          rd_d    = xfer.rd;
          ce_d    = 1'b1;
          tmr_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_q == TMR_LAST) begin
          tmr_d    = '0;
          sh_start = 1'b1;
          state_d  = ST_SHIFT;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_SHIFT: begin
        // !sh_busy only recovers from an engine that stopped without a done pulse.
        if (sh_done || !sh_busy) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (tmr_q == TMR_LAST) begin
          tmr_d   = '0;
          ce_d    = 1'b0;
          state_d = ST_RECOVER;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_RECOVER: begin
        if (tmr_q == TMR_LAST) begin
          tmr_d   = '0;
          state_d = ST_DONE;
          if (rd_q) rdata_d = sh_rx;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      ST_DONE: state_d = ST_WAIT_CLR;
      ST_WAIT_CLR: begin
        if (cmd_sig == 8'h00) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      ce_q    <= 1'b0;
      rd_q    <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ce_q    <= ce_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  ds1302_shift #(.HALF_DIV(HALF_DIV)) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .load_addr (xfer.addr),
    .load_data (xfer.data),
    .load_rd   (xfer.rd),
    .start     (sh_start),
    .rtc_io_in (rtc_io_in),
    .busy      (sh_busy),
    .done      (sh_done),
    .rx_data   (sh_rx),
    .sclk      (rtc_sclk),
    .io_out    (rtc_io_out),
    .io_oe     (rtc_io_oe)
  );

  assign rtc_ce         = ce_q;
  assign cmd_done       = done_q;
  assign time_read_data = rdata_q;

endmodule
